sim_uart_rx_mon: RTL and testbench

Simulation-side UART receiver for the Verilator chip top. It consumes the chip's UART TX pad output (`mio_out[33]`), deserializes 8N1 frames at a fixed clocks-per-bit ratio and buffers decoded bytes in a small FIFO. Testbench logic reads bytes through a valid/ready interface, so console output can be checked in RTL without the DPI host side. It reports framing errors and FIFO overflow as single-cycle pulses.

---
 rtl/sim_uart_rx_mon.sv | 150 +++++++++++++++
 tb/tb_sim_uart_rx_mon.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_uart_rx_mon.sv
// Simulation-side 8N1 UART receiver watching the chip UART TX pad.
// Decoded bytes queue in a small FIFO read through a valid/ready port.
module sim_uart_rx_mon #(
  parameter int ClkPerBit = 69,
  parameter int FifoDepth = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         rx_i,
  input  logic                         enable_i,
  output logic [7:0]                   rdata_o,
  output logic                         rvalid_o,
  input  logic                         rready_i,
  output logic                         frame_err_o,
  output logic                         overflow_o,
  output logic [$clog2(FifoDepth):0]   fifo_depth_o,
  output logic                         idle_o
);

  localparam int CW = $clog2(ClkPerBit);
  localparam int AW = $clog2(FifoDepth);
  localparam int DW = AW + 1;
  localparam logic [CW-1:0] CntHalf = CW'(ClkPerBit / 2 - 1);
  localparam logic [CW-1:0] CntLast = CW'(ClkPerBit - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_HIGH
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          ferr_q;
  logic          rx_m_q, rx_s_q, rx_prev_q;

  logic [7:0]    mem_q [FifoDepth];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [DW-1:0] count_q;
  logic          ovf_q;

  logic stop_hit, push, ferr, full, pop, wr;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_m_q    <= rx_i;
      rx_s_q    <= rx_m_q;
      rx_prev_q <= rx_s_q;
    end
  end

  assign stop_hit = enable_i && (state_q == STOP)
                 && (cnt_q == CntLast);
  assign push     = stop_hit && rx_s_q;
  assign ferr     = stop_hit && !rx_s_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ferr_q  <= 1'b0;
    end else begin
      ferr_q <= ferr;
      if (!enable_i) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_prev_q && !rx_s_q) begin
              state_q <= START;
              cnt_q   <= '0;
            end
          end
          START: begin
            if (cnt_q == CntHalf) begin
              cnt_q   <= '0;
              bit_q   <= '0;
              state_q <= rx_s_q ? IDLE : DATA;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          DATA: begin
            if (cnt_q == CntLast) begin
              cnt_q       <= '0;
              sh_q[bit_q] <= rx_s_q;
              bit_q       <= bit_q + 3'd1;
              if (bit_q == 3'd7) state_q <= STOP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          STOP: begin
            if (cnt_q == CntLast) begin
              cnt_q   <= '0;
              state_q <= rx_s_q ? IDLE : WAIT_HIGH;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          WAIT_HIGH: begin
            // hold off until a break condition releases the line
            if (rx_s_q) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign full = (count_q == DW'(FifoDepth));
  assign pop  = rvalid_o && rready_i;
  assign wr   = push && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FifoDepth; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q <= push && !wr;
      if (wr) begin
        mem_q[wptr_q] <= sh_q;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      case ({wr, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o      = mem_q[rptr_q];
  assign rvalid_o     = (count_q != '0);
  assign fifo_depth_o = count_q;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;
  assign idle_o       = (state_q == IDLE);

endmodule

// File: tb/tb_sim_uart_rx_mon.sv
// Directed bench for sim_uart_rx_mon at 8 clocks per bit, 4-entry FIFO.
// Frames are driven bit by bit; a negedge monitor logs rises, pops, pulses.
module tb_sim_uart_rx_mon;

  localparam int CPB   = 8;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, rx, en, rready;
  logic [7:0]    rdata;
  logic          rvalid, ferr, ovf, idle;
  logic [DW-1:0] depth;

  sim_uart_rx_mon #(
    .ClkPerBit(CPB),
    .FifoDepth(DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .enable_i    (en),
    .rdata_o     (rdata),
    .rvalid_o    (rvalid),
    .rready_i    (rready),
    .frame_err_o (ferr),
    .overflow_o  (ovf),
    .fifo_depth_o(depth),
    .idle_o      (idle)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_err = 0;
  logic       rv_prev = 1'b0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         rise_q[$];
  logic [7:0] pop_q[$];

  always @(negedge clk) begin
    if (rvalid === 1'b1 && rv_prev !== 1'b1) rise_q.push_back(cyc);
    if (rvalid === 1'b1 && rready === 1'b1) pop_q.push_back(rdata);
    rv_prev <= rvalid;
    fe_cnt  <= fe_cnt + ((ferr === 1'b1) ? 1 : 0);
    ov_cnt  <= ov_cnt + ((ovf === 1'b1) ? 1 : 0);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // called at #1 after an edge; returns at #1 after the stop bit ends
  task automatic send(input logic [7:0] b, input logic stop,
                      output int e0);
    e0 = cyc;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  function automatic int pop_at(input int i);
    return (i < pop_q.size()) ? int'(pop_q[i]) : -1;
  endfunction

  int e0a, e0b, e, fe0, ov0, r0;

  initial begin
    rst = 1'b1; rx = 1'b1; en = 1'b1; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rvalid", int'(rvalid), 0);
    check("rst_ferr", int'(ferr), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_depth", int'(depth), 0);
    check("rst_idle", int'(idle), 1);
    check("rst_rdata", int'(rdata), 0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // back-to-back frames, consumer always ready
    rready = 1'b1;
    rise_q.delete(); pop_q.delete();
    send(8'h55, 1'b1, e0a);
    send(8'hA3, 1'b1, e0b);
    check("b2b_rises", rise_q.size(), 2);
    check("b2b_rise0", (rise_q.size() > 0) ? rise_q[0] : -1, e0a + 79);
    check("b2b_rise1", (rise_q.size() > 1) ? rise_q[1] : -1, e0b + 79);
    check("b2b_pops", pop_q.size(), 2);
    check("b2b_byte0", pop_at(0), 'h55);
    check("b2b_byte1", pop_at(1), 'hA3);
    check("b2b_ferr", fe_cnt, 0);
    check("b2b_ovf", ov_cnt, 0);

    // framing error then recovery
    fe0 = fe_cnt;
    r0  = rise_q.size();
    send(8'h3C, 1'b0, e);
    check("fe_waithigh", int'(idle), 0);
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("fe_idle", int'(idle), 1);
    check("fe_pulse", fe_cnt - fe0, 1);
    check("fe_nopush", rise_q.size(), r0);
    check("fe_depth", int'(depth), 0);
    pop_q.delete();
    send(8'h01, 1'b1, e);
    check("fe_next_pops", pop_q.size(), 1);
    check("fe_next_byte", pop_at(0), 'h01);

    // two-cycle glitch: false start
    fe0 = fe_cnt; ov0 = ov_cnt; r0 = rise_q.size();
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("gl_start", int'(idle), 0);
    repeat (10) @(posedge clk);
    #1;
    check("gl_idle", int'(idle), 1);
    check("gl_nopush", rise_q.size(), r0);
    check("gl_ferr", fe_cnt - fe0, 0);
    check("gl_ovf", ov_cnt - ov0, 0);

    // overflow with consumer stalled
    rready = 1'b0;
    ov0 = ov_cnt;
    for (int k = 0; k < 4; k++) send(8'(8'h10 + k), 1'b1, e);
    check("of_full", int'(depth), 4);
    check("of_none_yet", ov_cnt - ov0, 0);
    send(8'h14, 1'b1, e);
    check("of_pulse", ov_cnt - ov0, 1);
    check("of_depth", int'(depth), 4);
    pop_q.delete();
    rready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rready = 1'b0;
    check("of_pops", pop_q.size(), 4);
    check("of_b0", pop_at(0), 'h10);
    check("of_b1", pop_at(1), 'h11);
    check("of_b3", pop_at(3), 'h13);
    check("of_empty", int'(depth), 0);

    // full push coinciding with a pop
    for (int k = 0; k < 4; k++) send(8'(8'h20 + k), 1'b1, e);
    pop_q.delete();
    ov0 = ov_cnt;
    fork
      send(8'h24, 1'b1, e);
      begin
        repeat (78) @(posedge clk);
        #1 rready = 1'b1;
        @(posedge clk);
        #1 rready = 1'b0;
      end
    join
    check("sp_ovf", ov_cnt - ov0, 0);
    check("sp_depth", int'(depth), 4);
    check("sp_pop0", pop_at(0), 'h20);
    rready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("sp_pops", pop_q.size(), 5);
    check("sp_last", pop_at(4), 'h24);
    check("sp_empty", int'(depth), 0);

    // enable dropped during bit 3
    pop_q.delete();
    r0 = rise_q.size();
    fork
      send(8'hFF, 1'b1, e);
      begin
        repeat (34) @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1;
        check("en_idle", int'(idle), 1);
        @(posedge clk);
        #1 en = 1'b1;
      end
    join
    check("en_nopush", rise_q.size(), r0);
    send(8'h42, 1'b1, e);
    check("en_next_pops", pop_q.size(), 1);
    check("en_next_byte", pop_at(0), 'h42);

    // reset mid-frame with two bytes queued
    rready = 1'b0;
    send(8'h11, 1'b1, e);
    send(8'h22, 1'b1, e);
    check("rs_queued", int'(depth), 2);
    fork
      send(8'hF0, 1'b1, e);
      begin
        repeat (50) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rs_rvalid", int'(rvalid), 0);
        check("rs_depth", int'(depth), 0);
        check("rs_rdata", int'(rdata), 0);
        check("rs_idle", int'(idle), 1);
        check("rs_ferr", int'(ferr), 0);
        check("rs_ovf", int'(ovf), 0);
        rst = 1'b0;
      end
    join
    check("rs_stay_empty", int'(depth), 0);
    rready = 1'b1;
    pop_q.delete();
    send(8'h7E, 1'b1, e);
    check("rs_next_pops", pop_q.size(), 1);
    check("rs_next_byte", pop_at(0), 'h7E);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
